// File: rtl/rfarb_pkg.sv
// Shared widths, the FIFO entry layout and the register one-hot decode
// used by the register file write arbiter.
package rfarb_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int DATA_W       = 32;
  localparam int ENTRY_W      = REG_IDX_W + DATA_W;
  localparam int STARVE_CNT_W = 4;

  // Entry layout is {reg, data}; idx is the destination register.
  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
  } entry_t;

  function automatic logic [DATA_W-1:0] reg_onehot(input logic [REG_IDX_W-1:0] r);
    return 32'd1 << r;
  endfunction

endpackage

// File: rtl/rfarb_fifo.sv
// Auxiliary write FIFO: DEPTH-entry synchronous queue with per-slot valid and
// register-index outputs so the top can build the pending-register mask.
module rfarb_fifo
  import rfarb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              push_i,
  input  logic [ENTRY_W-1:0]                push_entry_i,
  input  logic                              pop_i,
  output logic [$clog2(DEPTH):0]            count_o,
  output logic [ENTRY_W-1:0]                head_o,
  output logic [DEPTH-1:0]                  valid_o,
  output logic [DEPTH-1:0][REG_IDX_W-1:0]   reg_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DEPTH-1:0]   valid_q;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Slot valid bits are tracked explicitly; a push and a pop never hit the
  // same slot in one cycle because push needs not-full and pop needs not-empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_i) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = valid_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign reg_o[i] = mem_q[i][ENTRY_W-1 -: REG_IDX_W];
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between WB (priority) and a buffered
// auxiliary requester. Macro RFARB_STARVE_GUARD_EN enables the starvation guard.
module regfile_write_arbiter
  import rfarb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  WbReg,
  input  logic [31:0] WbData,
  input  logic        WbWrite,
  input  logic        AuxValid,
  input  logic [4:0]  AuxReg,
  input  logic [31:0] AuxData,
  output logic        AuxReady,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic        Stall,
  output logic [31:0] PendingMask
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      STARVE_LIMIT < 1 || STARVE_LIMIT >= (1 << STARVE_CNT_W)) begin : g_bad_param
    $error("regfile_write_arbiter: DEPTH must be a power of two >= 2, STARVE_LIMIT 1..15");
  end

  logic [CNT_W-1:0]                 count;
  logic [ENTRY_W-1:0]               head_raw;
  entry_t                           head;
  logic [DEPTH-1:0]                 slot_valid;
  logic [DEPTH-1:0][REG_IDX_W-1:0]  slot_reg;
  logic                             fifo_empty;
  logic                             enq;
  logic                             grant_wb, grant_head;
  logic [DATA_W-1:0]                mask;

  assign head       = entry_t'(head_raw);
  assign fifo_empty = (count == '0);
  assign AuxReady   = (count < DEPTH_C);
  // Writes to r0 complete the handshake but are dropped here.
  assign enq        = AuxValid && AuxReady && (AuxReg != '0);

  rfarb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (enq),
    .push_entry_i ({AuxReg, AuxData}),
    .pop_i        (grant_head),
    .count_o      (count),
    .head_o       (head_raw),
    .valid_o      (slot_valid),
    .reg_o        (slot_reg)
  );

  always_comb begin
    grant_wb   = 1'b0;
    grant_head = 1'b0;
    if (Stall) begin
      grant_head = !fifo_empty;
    end else if (WbWrite) begin
      grant_wb = 1'b1;
    end else begin
      grant_head = !fifo_empty;
    end
  end

  always_comb begin
    WriteReg  = '0;
    WriteData = '0;
    if (grant_wb) begin
      WriteReg  = WbReg;
      WriteData = WbData;
    end else if (grant_head) begin
      WriteReg  = head.idx;
      WriteData = head.data;
    end
  end

  assign RegWrite = (grant_wb || grant_head) && (WriteReg != '0);

  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) begin
        mask = mask | reg_onehot(slot_reg[i]);
      end
    end
  end

  assign PendingMask = mask & ~32'd1;

`ifdef RFARB_STARVE_GUARD_EN
  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic                    stall_q, stall_d;

  // Stall is registered off the next counter value, so it lands in the cycle
  // right after the LIMIT-th wait; granting the head then clears the counter.
  always_comb begin
    if (fifo_empty || grant_head) begin
      starve_d = '0;
    end else if (starve_q == LIMIT_C) begin
      starve_d = starve_q;
    end else begin
      starve_d = starve_q + 1'b1;
    end
    stall_d = (starve_d == LIMIT_C);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign Stall = stall_q;
`else
  assign Stall = 1'b0;
`endif

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

- Shares the register file's single write port between two sources:
  - the pipeline writeback stage (WB, highest priority);
  - an auxiliary long-latency requester, such as a multicycle divider or a load-miss return.
- Auxiliary writes are held in a small FIFO and drained on cycles when WB does not write.
- A starvation guard forces a drain by stalling WB for one cycle.
- A pending-register mask lets the hazard unit interlock on registers with outstanding auxiliary writes.

## Interface

Parameters:
- DEPTH, 2 — auxiliary FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 4 — wait cycles of the FIFO head before a forced drain; range 1..15.

Ports:
- clock  in  1  — system clock; all state updates on the rising edge.
- reset  in  1  — synchronous, active-high; clears all state.
- WbReg  in  5  — WB destination register index.
- WbData  in  32  — WB write data.
- WbWrite  in  1  — WB write request.
- AuxValid  in  1  — auxiliary write offered.
- AuxReg  in  5  — auxiliary destination register index.
- AuxData  in  32  — auxiliary write data.
- AuxReady  out  1  — FIFO can accept an entry this cycle.
- WriteReg  out  5  — to the register file write index.
- WriteData  out  32  — to the register file write data.
- RegWrite  out  1  — to the register file write enable.
- Stall  out  1  — WB frozen this cycle; auxiliary head owns the port.
- PendingMask  out  32  — bit r set while any FIFO entry targets register r; bit 0 is always 0.

## Operation

Auxiliary acceptance:
- An entry is accepted on a rising edge when AuxValid && AuxReady.
- AuxReady = (count < DEPTH). It is a function of registered count only, never of AuxValid.
- A write to register 0 is consumed (handshake completes) but not enqueued.

Grant, evaluated each cycle:
- If Stall=1: grant the FIFO head.
- Else if WbWrite=1: grant WB.
- Else if FIFO is non-empty: grant the FIFO head.
- Else: no write.

Port drive and dequeue:
- WriteReg and WriteData come from the granted source.
- RegWrite = grant valid && WriteReg != 0. A WB write to register 0 is granted but produces RegWrite=0.
- The head is dequeued at the edge ending a cycle in which it was granted.
- Enqueue and dequeue in the same cycle leave count unchanged. Enqueue is impossible when full (AuxReady=0).

Starvation counter (4 bits):
- Clears when the FIFO is empty or the head is granted.
- Otherwise increments, saturating at STARVE_LIMIT.
- The registered Stall goes high on the cycle after the counter reaches STARVE_LIMIT and lasts exactly one cycle.

Stall contract:
- While Stall=1, WbWrite is ignored. WB holds its request and re-presents it the next cycle; no WB write is lost.
- If the FIFO is empty when Stall is high, the cycle is idle and no write occurs.

PendingMask:
- The OR of the one-hot decodes of all valid entries.
- Two entries to the same register keep the bit set until both drain.

Reset:
- FIFO empty (count=0), counter=0, Stall=0.
- Outputs therefore read AuxReady=1, PendingMask=0, and RegWrite=WbWrite && WbReg!=0.

## Timing

- WB path is combinational, zero latency: WbWrite in cycle n produces a register file write at the end of cycle n.
- Auxiliary path:
  - An entry accepted at edge n is writable at the earliest in cycle n+1.
  - Its PendingMask bit is set from cycle n+1 until the edge that dequeues it.
- Forced drain: with WB writing every cycle, the head waits STARVE_LIMIT cycles, Stall is high for one cycle, and the head is written in that Stall cycle.
- Reset asserted mid-operation discards all buffered entries at that edge. Their writes are lost; the auxiliary requester is also reset by system reset.
- No combinational path exists from AuxValid to AuxReady, or from any input to Stall.

## Configuration

- RFARB_STARVE_GUARD_EN defined: the starvation counter and Stall are built as described above.
- RFARB_STARVE_GUARD_EN undefined:
  - the counter is removed and Stall is tied to 0;
  - the FIFO drains only on cycles with WbWrite=0;
  - the hazard unit relies solely on PendingMask, and liveness depends on WB idle cycles.

## Structure

- Shared package rfarb_pkg holds:
  - REG_IDX_W=5, DATA_W=32;
  - ENTRY_W = REG_IDX_W + DATA_W, with the entry field layout {reg, data};
  - STARVE_CNT_W=4.
- One sub-module, rfarb_fifo:
  - DEPTH-entry synchronous FIFO with count, head outputs, and per-entry valid/reg outputs used by the PendingMask decode;
  - arbitration, starvation counter and mask logic stay in the top module.

## Test plan

- Reset, then WbWrite=1, WbReg=5, WbData=0xDEADBEEF → same cycle WriteReg=5, RegWrite=1; AuxReady=1; PendingMask=0.
- AuxValid with AuxReg=7, AuxData=0x12345678 while WB is idle → accepted at edge n; cycle n+1 shows WriteReg=7, RegWrite=1, PendingMask[7]=1; mask cleared at edge n+1.
- Two auxiliary entries to register 9 while WB writes every cycle → AuxReady=0 at count 2; PendingMask[9] stays 1 until the second dequeue.
- WB writing continuously with one auxiliary entry, STARVE_LIMIT=4, guard enabled → Stall=1 exactly one cycle after 4 waits; head written then; WB write re-presented and written next cycle.
- Auxiliary write to register 0 and WB write to register 0 → handshake completes, no enqueue, PendingMask=0, RegWrite=0.
- Two entries buffered, reset asserted → next cycle count=0, AuxReady=1, PendingMask=0, Stall=0, no auxiliary writes appear.
